// File: rtl/tt_um_hoene_led_pwm_multi.sv
`default_nettype none
// ============================================================================
// Module   : tt_um_hoene_led_pwm_multi
// Function : Multi-channel LED PWM with shadow duty registers and
//            period-synchronous commit. Optional LED_PWM_PHASE_SHIFT_EN
//            staggers channel phases across the period.
// Revision : 1.0 - initial release
// ============================================================================
module tt_um_hoene_led_pwm_multi #(
    parameter int CHANNELS = 3,
    parameter int WIDTH    = 10,
    parameter int PRESCALE = 1
) (
    input  logic                                              clk,
    input  logic                                              rst_n,
    input  logic                                              enable,
    input  logic                                              load_valid,
    output logic                                              load_ready,
    input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] load_ch,
    input  logic [WIDTH-1:0]                                  load_data,
    input  logic                                              commit,
    output logic                                              commit_pending,
    output logic                                              period_start,
    output logic [CHANNELS-1:0]                               pwm_out
);

    localparam int               CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int               PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [WIDTH-1:0] MAX      = WIDTH'((1 << WIDTH) - 2);
    localparam logic [PW-1:0]    PRE_LAST = PW'(PRESCALE - 1);

    logic [WIDTH-1:0]    cnt;
    logic [PW-1:0]       pre;
    logic                tick;
    logic                boundary;
    logic                transfer;
    logic                load_fire;
    logic [WIDTH-1:0]    shadow [CHANNELS];
    logic [WIDTH-1:0]    active [CHANNELS];
    logic [CHANNELS-1:0] pwm_next;

    assign tick       = (pre == PRE_LAST);
    assign boundary   = enable && tick && (cnt == MAX);
    // A disabled PWM has no period to tear, so a pending commit lands at once.
    assign transfer   = commit_pending && (boundary || !enable);
    assign load_ready = !commit_pending;
    assign load_fire  = load_valid && load_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            pre <= '0;
        end else if (!enable) begin
            cnt <= '0;
            pre <= '0;
        end else begin
            pre <= tick ? '0 : pre + 1'b1;
            if (tick) begin
                cnt <= (cnt == MAX) ? '0 : cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            commit_pending <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
        end else begin
            // Out-of-range channel numbers match no entry and are dropped.
            for (int i = 0; i < CHANNELS; i++) begin
                if (load_fire && (load_ch == CW'(i))) begin
                    shadow[i] <= load_data;
                end
            end
            if (transfer) begin
                for (int i = 0; i < CHANNELS; i++) begin
                    active[i] <= shadow[i];
                end
                commit_pending <= 1'b0;
            end else if (commit) begin
                commit_pending <= 1'b1;
            end
        end
    end

    generate
        for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
`ifdef LED_PWM_PHASE_SHIFT_EN
            localparam logic [WIDTH:0] PERIOD = (WIDTH+1)'((1 << WIDTH) - 1);
            localparam logic [WIDTH:0] OFF    = (WIDTH+1)'((g * ((1 << WIDTH) - 1)) / CHANNELS);
            logic [WIDTH:0]   sum;
            logic [WIDTH-1:0] phase;
            assign sum   = {1'b0, cnt} + OFF;
            assign phase = (sum >= PERIOD) ? WIDTH'(sum - PERIOD) : sum[WIDTH-1:0];
`else
            logic [WIDTH-1:0] phase;
            assign phase = cnt;
`endif
            assign pwm_next[g] = enable && (phase < active[g]);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_out      <= '0;
            period_start <= 1'b0;
        end else begin
            pwm_out      <= pwm_next;
            period_start <= enable && (cnt == '0) && (pre == '0);
        end
    end

endmodule
`default_nettype wire
